// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write/clear arbiter for a register bank; `define REG_ARB_PRIO0_EN makes requester 0 fixed-priority
module reg_bank_arbiter #(
   parameter int MAX_WIDTH = 8,
   parameter int NUM_REQ   = 4,
   parameter int NUM_REGS  = 4,
   parameter int ADDR_W    = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0]             req_clr,
   input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
   input  logic [NUM_REQ*MAX_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REGS-1:0]            reg_en,
   output logic [NUM_REGS-1:0]            reg_sclr,
   output logic [MAX_WIDTH-1:0]           reg_d,
   output logic                           busy
);
   localparam int PW = $clog2(NUM_REQ);
`ifdef REG_ARB_PRIO0_EN
   localparam int LO = 1;
`else
   localparam int LO = 0;
`endif
   logic [PW-1:0]        ptr, ptr_nxt, w;
   logic [NUM_REQ-1:0]   e;
   logic [ADDR_W-1:0]    addr;
   logic [MAX_WIDTH-1:0] data;
   logic                 found;
   int                   idx;
   always_comb begin
      e = req & ~gnt;
      found = 1'b0;
      w = '0;
      idx = 0;
      // rotating search over the ring LO..NUM_REQ-1 starting at ptr
      for (int i = 0; i < NUM_REQ - LO; i++) begin
         idx = LO + (int'(ptr) - LO + i) % (NUM_REQ - LO);
         if (!found && e[idx]) begin
            found = 1'b1;
            w = PW'(idx);
         end
      end
`ifdef REG_ARB_PRIO0_EN
      if (e[0]) begin
         found = 1'b1;
         w = '0;
      end
`endif
      ptr_nxt = (found && (LO == 0 || w != '0)) ? ((int'(w) == NUM_REQ - 1) ? PW'(LO) : w + 1'b1) : ptr;
      addr = req_addr[w*ADDR_W +: ADDR_W];
      data = req_data[w*MAX_WIDTH +: MAX_WIDTH];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt      <= '0;
         reg_en   <= '0;
         reg_sclr <= '0;
         reg_d    <= '0;
         ptr      <= PW'(LO);
      end else begin
         gnt      <= found ? NUM_REQ'(1) << w : '0;
         reg_en   <= (found && !req_clr[w]) ? NUM_REGS'(1) << addr : '0;
         reg_sclr <= (found && req_clr[w]) ? NUM_REGS'(1) << addr : '0;
         reg_d    <= found ? data : reg_d;
         ptr      <= ptr_nxt;
      end
   end
   assign busy = |gnt;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: scoreboard bench for reg_bank_arbiter with a behavioural register bank
module tb_reg_bank_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic [3:0] req = '0, req_clr = '0;
   logic [7:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [3:0] gnt, reg_en, reg_sclr;
   logic [7:0] reg_d;
   logic busy;
   logic [7:0] bank [4];
   typedef struct packed {logic [3:0] g; logic [3:0] en; logic [3:0] sc; logic [7:0] d;} exp_t;
   exp_t sb[$];
   exp_t x;
   int checks = 0, failures = 0, cyc = 0, last_cyc = 0;

   reg_bank_arbiter #(.MAX_WIDTH(8), .NUM_REQ(4), .NUM_REGS(4), .ADDR_W(2)) dut (
      .clk(clk), .rst(rst), .req(req), .req_clr(req_clr), .req_addr(req_addr),
      .req_data(req_data), .gnt(gnt), .reg_en(reg_en), .reg_sclr(reg_sclr),
      .reg_d(reg_d), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(posedge clk)
      for (int k = 0; k < 4; k++)
         if (reg_sclr[k]) bank[k] <= 8'h00;
         else if (reg_en[k]) bank[k] <= reg_d;

   // scoreboard monitor: every grant must match the oldest expected issue
   always @(negedge clk) begin
      checks++;
      if (!$onehot0(reg_en | reg_sclr) || (reg_en & reg_sclr) != 4'b0) begin
         failures++;
         $display("FAIL strobe_onehot: en=%b sclr=%b", reg_en, reg_sclr);
      end
      if (gnt !== 4'b0) begin
         checks++;
         last_cyc = cyc;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_grant: gnt=%b en=%b sclr=%b d=%h", gnt, reg_en, reg_sclr, reg_d);
         end else begin
            x = sb.pop_front();
            if ({gnt, reg_en, reg_sclr, reg_d, busy} !== {x.g, x.en, x.sc, x.d, 1'b1}) begin
               failures++;
               $display("FAIL issue: got gnt=%b en=%b sclr=%b d=%h busy=%b, want gnt=%b en=%b sclr=%b d=%h busy=1",
                        gnt, reg_en, reg_sclr, reg_d, busy, x.g, x.en, x.sc, x.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic set_req(input int k, input logic clr, input logic [1:0] a, input logic [7:0] d);
      req_clr[k] = clr;
      req_addr[k*2 +: 2] = a;
      req_data[k*8 +: 8] = d;
      req[k] = 1'b1;
   endtask

   task automatic push(input int k);
      exp_t e;
      e.g  = 4'b1 << k;
      e.en = req_clr[k] ? 4'b0 : 4'b1 << req_addr[k*2 +: 2];
      e.sc = req_clr[k] ? 4'b1 << req_addr[k*2 +: 2] : 4'b0;
      e.d  = req_data[k*8 +: 8];
      sb.push_back(e);
   endtask

   // requesters drop req the cycle after their grant unless listed in keep
   task automatic wait_sb(input logic [3:0] keep, input int budget, output bit ok);
      logic [3:0] seen;
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         seen = gnt;
         @(posedge clk);
         #1;
         req = req & ~(seen & ~keep);
         n++;
      end
      ok = (sb.size() == 0);
      sb.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) set_req(k, 1'b0, 2'(k), 8'h10 + 8'(k));
      repeat (2) begin
         @(negedge clk);
         checks++;
         if ({gnt, reg_en, reg_sclr, reg_d, busy} !== 21'b0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b en=%b sclr=%b d=%h busy=%b, want all 0", gnt, reg_en, reg_sclr, reg_d, busy);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_fairness();
      bit ok;
      int a = cyc;
      for (int k = 0; k < 4; k++) push(k);
      wait_sb(4'b0, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL fairness_timeout: grants missing"); end
      checks++;
      if (last_cyc - a != 4) begin failures++; $display("FAIL fairness_gaps: span=%0d want 4", last_cyc - a); end
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0) begin failures++; $display("FAIL fairness_idle: gnt=%b want 0000", gnt); end
      checks++;
      if (bank[3] !== 8'h13) begin failures++; $display("FAIL fairness_bank: bank3=%h want 13", bank[3]); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_contention();
      bit ok;
      int a = cyc;
      set_req(0, 1'b0, 2'd1, 8'h11);
      set_req(3, 1'b0, 2'd1, 8'h33);
      push(0);
      push(3);
      wait_sb(4'b0, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL contention_timeout: grants missing"); end
      checks++;
      if (last_cyc - a != 2) begin failures++; $display("FAIL contention_b2b: span=%0d want 2", last_cyc - a); end
      checks++;
      if (bank[1] !== 8'h33) begin failures++; $display("FAIL contention_last_writer: bank1=%h want 33", bank[1]); end
   endtask

   task automatic test_write();
      bit ok;
      int a = cyc;
      set_req(2, 1'b0, 2'd3, 8'hA5);
      sb.push_back('{g: 4'b0100, en: 4'b1000, sc: 4'b0000, d: 8'hA5});
      wait_sb(4'b0, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL write_timeout: grant missing"); end
      checks++;
      if (last_cyc - a != 1) begin failures++; $display("FAIL write_latency: latency=%0d want 1", last_cyc - a); end
      checks++;
      if (bank[3] !== 8'hA5) begin failures++; $display("FAIL write_bank: bank3=%h want a5", bank[3]); end
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0) begin failures++; $display("FAIL write_single_grant: gnt=%b want 0000", gnt); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clear();
      bit ok;
      set_req(1, 1'b1, 2'd0, 8'h5A);
      sb.push_back('{g: 4'b0010, en: 4'b0000, sc: 4'b0001, d: 8'h5A});
      wait_sb(4'b0, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL clear_timeout: grant missing"); end
      checks++;
      if (bank[0] !== 8'h00) begin failures++; $display("FAIL clear_bank: bank0=%h want 00", bank[0]); end
   endtask

   task automatic test_mid_reset();
      bit ok;
      set_req(1, 1'b0, 2'd3, 8'h99);
      set_req(2, 1'b0, 2'd2, 8'h77);
      sb.push_back('{g: 4'b0100, en: 4'b0100, sc: 4'b0000, d: 8'h77});
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = 4'b0;
      set_req(1, 1'b0, 2'd3, 8'h99);
      set_req(3, 1'b0, 2'd0, 8'h42);
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL midrst_grant: grant to 2 missing"); sb.delete(); end
      @(negedge clk);
      checks++;
      if ({gnt, reg_en, reg_sclr, reg_d, busy} !== 21'b0) begin
         failures++;
         $display("FAIL midrst_drop: gnt=%b en=%b sclr=%b d=%h busy=%b, want all 0", gnt, reg_en, reg_sclr, reg_d, busy);
      end
      push(1);
      push(3);
      wait_sb(4'b0, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL midrst_ptr: grants missing or out of order"); end
      checks++;
      if (bank[3] !== 8'h99 || bank[0] !== 8'h42) begin
         failures++;
         $display("FAIL midrst_bank: bank3=%h bank0=%h want 99 42", bank[3], bank[0]);
      end
   endtask

`ifdef REG_ARB_PRIO0_EN
   task automatic test_prio0();
      bit ok;
      int a;
      rst = 1'b1;
      req = 4'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      a = cyc;
      for (int k = 0; k < 4; k++) set_req(k, 1'b0, 2'(k), 8'hC0 + 8'(k));
      push(0); push(1); push(0); push(2); push(0); push(3); push(0);
      wait_sb(4'b0001, 30, ok);
      req = 4'b0;
      checks++;
      if (!ok) begin failures++; $display("FAIL prio0_order: grants missing"); end
      checks++;
      if (last_cyc - a != 7) begin failures++; $display("FAIL prio0_gaps: span=%0d want 7", last_cyc - a); end
   endtask
`endif

   initial begin
      test_reset();
      test_fairness();
      test_contention();
      test_write();
      test_clear();
      test_mid_reset();
`ifdef REG_ARB_PRIO0_EN
      test_prio0();
`endif
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Round-robin write arbiter that shares a bank of NUM_REGS registers among NUM_REQ requesters.
- Each register in the bank has its own enable, synchronous clear and data inputs.
- The block drives the per-register en/sclr strobes and a shared data bus, and returns a one-hot grant to the winning requester.
- It sits between the datapath control units (requesters) and the register bank.

Parameters:
- MAX_WIDTH, 8: data width of each register and of reg_d.
- NUM_REQ, 4: number of requesters (2..8).
- NUM_REGS, 4: number of registers in the bank (power of 2, 2..16).
- ADDR_W, 2: register address width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  clock; everything is sampled on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write/clear request, level, held until granted.
- req_clr  input  NUM_REQ  per-requester op select: 1 = clear target register, 0 = write data.
- req_addr  input  NUM_REQ*ADDR_W  flattened target addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*MAX_WIDTH  flattened write data; requester k uses bits [k*MAX_WIDTH +: MAX_WIDTH].
- gnt  output  NUM_REQ  one-hot grant pulse, registered.
- reg_en  output  NUM_REGS  one-hot register write enable, registered.
- reg_sclr  output  NUM_REGS  one-hot register synchronous clear, registered.
- reg_d  output  MAX_WIDTH  shared write data to the bank, registered.
- busy  output  1  high in any cycle where gnt is nonzero.

Behaviour:
- Interface (decided): single clock clk; reset rst is synchronous and active-high; there is no asynchronous reset path.
- Reset values:
  - gnt, reg_en, reg_sclr, reg_d, busy all 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
- Reset mid-operation: any pending strobe is dropped the cycle after rst is sampled; no partial write is issued.
- Eligible set: E = req & ~gnt. A requester granted in the current cycle is ignored that same cycle, which absorbs its one-cycle req deassert latency.
- Arbitration (combinational on E), winner w:
  - Search starts at pointer p: indices p, p+1, ... NUM_REQ-1, 0, ... p-1; w is the first eligible index.
  - If E is 0: next gnt, reg_en, reg_sclr = 0; reg_d holds its value; pointer unchanged.
- Issue (registered, latency 1): when req is sampled at edge N, then in cycle N+1:
  - gnt[w] = 1 for exactly one cycle.
  - If req_clr[w] = 1: reg_sclr[addr_w] = 1 and reg_en = 0.
  - If req_clr[w] = 0: reg_en[addr_w] = 1 and reg_sclr = 0.
  - reg_d = data_w in both cases; it is don't-care to the bank on a clear.
  - Pointer becomes (w+1) mod NUM_REQ.
- Bank update occurs at the edge ending cycle N+1, so a write is visible at the bank q output 2 cycles after req is sampled.
- Throughput: one grant per cycle. Back-to-back grants to different requesters are allowed. The same requester can be granted at most every 2nd cycle.
- Requester rules:
  - Hold req, req_clr, req_addr and req_data stable until gnt is seen.
  - Deassert req in the cycle after gnt, or keep it high to issue a new request.
- Invariants: at most one bit is set across reg_en | reg_sclr in any cycle; reg_en & reg_sclr is always 0.
- Same-address requests from multiple requesters: serialized in round-robin order; the last writer wins.
- Address wrap: addr is ADDR_W bits and therefore always in range.

Optional Feature:
- Macro REG_ARB_PRIO0_EN.
- Defined: requester 0 is fixed-priority.
  - If E[0] = 1, requester 0 wins regardless of the pointer, and the pointer is not updated.
  - Otherwise round-robin runs over requesters 1..NUM_REQ-1 only; the pointer never selects 0 and its reset value is 1.
- Undefined: pure round-robin over all requesters, as described in Behaviour.

Test Plan:
- Reset check: assert rst for 2 cycles with req = 4'b1111 -> gnt, reg_en, reg_sclr, reg_d all 0 throughout; first grant after release goes to requester 0.
- Single write: req[2] = 1, addr = 3, data = 8'hA5, clr = 0 -> one cycle later gnt = 4'b0100, reg_en = 4'b1000, reg_d = 8'hA5; the bank register at addr 3 holds 8'hA5 one cycle after that.
- Clear: req[1] = 1, clr = 1, addr = 0 -> reg_sclr = 4'b0001, reg_en = 0, gnt = 4'b0010; register 0 reads 0 on the next cycle.
- Fairness: all four requesters held continuously, each dropping req the cycle after its own grant -> grants in order 0,1,2,3, one per cycle, no repeats, no gaps.
- Contention and mid-op reset: requesters 0 and 3 both write addr 1 (11h and 33h) -> serialized grants 0 then 3, final value 33h. Then rst in the cycle after a grant -> no strobe in the following cycle, and the pointer returns to 0.
- REG_ARB_PRIO0_EN defined: req = 4'b1111 held with requester 0 re-requesting every other cycle -> grants 0,1,0,2,0,3.
